// File: rtl/button_event_if.sv
// rtl/button_event_if.sv - button level in, single-cycle game events out
//
// Purpose : bundles the debounced button level, the enable and the event
//           outputs of button_event into one interface.
// Signals : btn_level, enable           - driven by the master (debouncer side)
//           press_pulse, release_pulse,
//           click_pulse, long_pulse,
//           repeat_pulse, held          - driven by the slave (button_event)
interface button_event_if;
    logic btn_level;
    logic enable;
    logic press_pulse;
    logic release_pulse;
    logic click_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output btn_level,
        output enable,
        input  press_pulse,
        input  release_pulse,
        input  click_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  btn_level,
        input  enable,
        output press_pulse,
        output release_pulse,
        output click_pulse,
        output long_pulse,
        output repeat_pulse,
        output held
    );
endinterface

// File: rtl/button_event.sv
// rtl/button_event.sv - debounced button level to press/release/click/long/repeat events
//
// Purpose : converts a clean clk-synchronous button level into registered
//           single-cycle events for the game control FSM.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - button_event_if.slave: btn_level/enable in,
//                   press/release/click/long/repeat pulses and held out
module button_event #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned LONG_CYCLES   = 50000,
    parameter int unsigned REPEAT_CYCLES = 10000
) (
    input  logic           clk,
    input  logic           rst_n,
    button_event_if.slave  bus
);

    // Terminal counts; LONG_CYCLES may be 2^CNT_W, so the subtraction is
    // done in 32 bits before truncating to the counter width.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam bit               REPEAT_EN   = (REPEAT_CYCLES != 0);
    localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_EN ? CNT_W'(REPEAT_CYCLES - 1) : '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHORT = 2'd1,
        S_LONG  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    logic rise;
    logic cnt_at_long;
    logic cnt_at_repeat;

    assign rise          = bus.btn_level & ~prev_q;
    assign cnt_at_long   = (cnt_q == LONG_LAST);
    assign cnt_at_repeat = REPEAT_EN && (cnt_q == REPEAT_LAST);

    // State register. prev resets to 1 so a button already held when reset
    // is released has to go low and high again before it counts as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= bus.btn_level;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    // Next-state and hold counter. Release always wins over a threshold hit
    // in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_d = S_SHORT;
                        cnt_d   = '0;
                    end
                end
                S_SHORT: begin
                    if (!bus.btn_level) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_at_long) begin
                        state_d = S_LONG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_LONG: begin
                    if (!bus.btn_level) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_at_repeat) begin
                        cnt_d = '0;
                    end else if (cnt_q != '1) begin
                        // With repeat disabled the counter parks at all-ones
                        // instead of wrapping.
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Event outputs, registered at the same edge as the state change.
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        held_d    = (state_d != S_IDLE);
        if (bus.enable) begin
            case (state_q)
                S_IDLE: begin
                    press_d = rise;
                end
                S_SHORT: begin
                    release_d = ~bus.btn_level;
                    click_d   = ~bus.btn_level;
                    long_d    = bus.btn_level & cnt_at_long;
                end
                S_LONG: begin
                    release_d = ~bus.btn_level;
                    repeat_d  = bus.btn_level & cnt_at_repeat;
                end
                default: begin
                    press_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.click_pulse   = click_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - directed self-checking bench for button_event
module tb_button_event;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn   = 1'b1;
    logic en    = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    button_event_if if_a ();
    button_event_if if_b ();

    assign if_a.btn_level = btn;
    assign if_a.enable    = en;
    assign if_b.btn_level = btn;
    assign if_b.enable    = en;

    button_event #(.CNT_W(16), .LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    button_event #(.CNT_W(4), .LONG_CYCLES(8), .REPEAT_CYCLES(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    // {press, release, click, long, repeat, held}
    wire [5:0] obs_a = {if_a.press_pulse, if_a.release_pulse, if_a.click_pulse,
                        if_a.long_pulse, if_a.repeat_pulse, if_a.held};
    wire [5:0] obs_b = {if_b.press_pulse, if_b.release_pulse, if_b.click_pulse,
                        if_b.long_pulse, if_b.repeat_pulse, if_b.held};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        btn = 1'b0;
        en  = 1'b1;
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        rst_n = 1'b0;
        btn   = 1'b1;
        en    = 1'b1;
        #12;
        n_checks++;
        if (obs_a !== 6'b0) $display("FAIL reset_a: got %b want %b", obs_a, 6'b0);
        else n_pass++;
        n_checks++;
        if (obs_b !== 6'b0) $display("FAIL reset_b: got %b want %b", obs_b, 6'b0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (obs_a !== 6'b0) $display("FAIL held_through_reset k=%0d: got %b want %b", k, obs_a, 6'b0);
            else n_pass++;
        end
        for (int k = 0; k <= 12; k++) begin
            btn = (k >= 10);
            step();
            exp = {k == 10, 1'b0, 1'b0, 1'b0, 1'b0, k >= 10};
            n_checks++;
            if (obs_a !== exp) $display("FAIL first_press k=%0d: got %b want %b", k, obs_a, exp);
            else n_pass++;
        end
    endtask

    task automatic test_short_click();
        logic [5:0] exp;
        go_idle();
        for (int k = 0; k <= 6; k++) begin
            btn = (k <= 4);
            step();
            exp = {k == 0, k == 5, k == 5, 1'b0, 1'b0, k < 5};
            n_checks++;
            if (obs_a !== exp) $display("FAIL short_click k=%0d: got %b want %b", k, obs_a, exp);
            else n_pass++;
        end
    endtask

    task automatic test_threshold_boundary();
        logic [5:0] exp;
        go_idle();
        for (int k = 0; k <= 9; k++) begin
            btn = (k <= 7);
            step();
            exp = {k == 0, k == 8, k == 8, 1'b0, 1'b0, k < 8};
            n_checks++;
            if (obs_a !== exp) $display("FAIL boundary k=%0d: got %b want %b", k, obs_a, exp);
            else n_pass++;
        end
    endtask

    task automatic test_long_repeat();
        logic [5:0] exp;
        go_idle();
        for (int k = 0; k <= 21; k++) begin
            btn = (k <= 19);
            step();
            exp = {k == 0, k == 20, 1'b0, k == 8, (k == 12) || (k == 16), k < 20};
            n_checks++;
            if (obs_a !== exp) $display("FAIL long_repeat k=%0d: got %b want %b", k, obs_a, exp);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        logic [5:0] exp;
        go_idle();
        for (int k = 0; k <= 7; k++) begin
            btn = (k <= 2) || (k == 4) || (k == 5);
            step();
            exp = {(k == 0) || (k == 4), (k == 3) || (k == 6), (k == 3) || (k == 6),
                   1'b0, 1'b0, (k < 3) || ((k >= 4) && (k < 6))};
            n_checks++;
            if (obs_a !== exp) $display("FAIL glitch k=%0d: got %b want %b", k, obs_a, exp);
            else n_pass++;
        end
    endtask

    task automatic test_enable();
        logic [5:0] exp;
        go_idle();
        for (int k = 0; k <= 14; k++) begin
            en  = !((k >= 5) && (k <= 8));
            btn = (k != 12);
            step();
            exp = {(k == 0) || (k == 13), 1'b0, 1'b0, 1'b0, 1'b0, (k < 5) || (k >= 13)};
            n_checks++;
            if (obs_a !== exp) $display("FAIL enable k=%0d: got %b want %b", k, obs_a, exp);
            else n_pass++;
        end
    endtask

    task automatic test_repeat_off_and_async_reset();
        int n_long = 0;
        int n_rep  = 0;
        go_idle();
        for (int k = 0; k <= 101; k++) begin
            btn = (k <= 99);
            step();
            if (if_b.long_pulse === 1'b1) n_long++;
            if (if_b.repeat_pulse === 1'b1) n_rep++;
            if (k == 8) begin
                n_checks++;
                if (if_b.long_pulse !== 1'b1) $display("FAIL norep_long_at_8: got %b want 1", if_b.long_pulse);
                else n_pass++;
            end
            if (k == 100) begin
                n_checks++;
                if (obs_b !== 6'b010000) $display("FAIL norep_release: got %b want %b", obs_b, 6'b010000);
                else n_pass++;
            end
        end
        n_checks++;
        if (n_long !== 1) $display("FAIL norep_long_count: got %0d want 1", n_long);
        else n_pass++;
        n_checks++;
        if (n_rep !== 0) $display("FAIL norep_repeat_count: got %0d want 0", n_rep);
        else n_pass++;

        // Hold again, then pulse reset asynchronously mid-cycle.
        go_idle();
        for (int k = 0; k < 20; k++) begin
            btn = 1'b1;
            step();
        end
        n_checks++;
        if (obs_b !== 6'b000001) $display("FAIL prereset_held_b: got %b want %b", obs_b, 6'b000001);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_a !== 6'b0) $display("FAIL async_reset_a: got %b want %b", obs_a, 6'b0);
        else n_pass++;
        n_checks++;
        if (obs_b !== 6'b0) $display("FAIL async_reset_b: got %b want %b", obs_b, 6'b0);
        else n_pass++;
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if ((obs_a !== 6'b0) || (obs_b !== 6'b0))
                $display("FAIL post_reset_hold k=%0d: got a=%b b=%b want 000000", k, obs_a, obs_b);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_short_click();
        test_threshold_boundary();
        test_long_repeat();
        test_glitch();
        test_enable();
        test_repeat_off_and_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumes the clean, debounced, clk-synchronous button level produced by the debouncer stage.
- Converts it into single-cycle game events: press, release, short click, long-press and auto-repeat.
- Sits between the debouncer and the game control FSM (jump/duck/restart logic), so downstream logic never edge-detects or times raw levels itself.

Parameters:
- CNT_W, 16, width of the internal hold counter.
- LONG_CYCLES, 16'd50000, cycles held before long_pulse; range 1..2^CNT_W.
- REPEAT_CYCLES, 16'd10000, auto-repeat period in LONG state; 0 disables repeat; range 0..2^CNT_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_level  input  1  debounced button level, already synchronous to clk; 1 = pressed.
- enable  input  1  1 = generate events; 0 = force idle.
- press_pulse  output  1  one-cycle pulse on an accepted 0->1 transition.
- release_pulse  output  1  one-cycle pulse on 1->0 while not IDLE.
- click_pulse  output  1  one-cycle pulse on release before the long threshold.
- long_pulse  output  1  one-cycle pulse when hold reaches LONG_CYCLES.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while in LONG.
- held  output  1  1 while state != IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Registers:
  - prev: btn_level from the previous cycle.
  - state: IDLE / SHORT / LONG.
  - cnt: CNT_W bits.
  - All outputs are registered.
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, all outputs 0.
  - prev=1, so a button already held at reset release produces no press until it is released and pressed again.
- Every edge: prev <= btn_level. All pulse outputs default to 0 each cycle, so each pulse lasts exactly 1 cycle.
- Rising edge: rise = btn_level & ~prev (sampled at the same edge).
- enable=0 (highest priority after reset): state<=IDLE, cnt<=0, no pulses, prev still updates.
- IDLE:
  - rise & enable -> SHORT, cnt<=0, press_pulse<=1.
  - A level held high with no rise stays in IDLE.
- SHORT:
  - btn_level=0 -> IDLE, release_pulse<=1, click_pulse<=1.
  - Else if cnt==LONG_CYCLES-1 -> LONG, cnt<=0, long_pulse<=1.
  - Else cnt<=cnt+1.
  - Release has priority over reaching the threshold in the same cycle.
- LONG:
  - btn_level=0 -> IDLE, release_pulse<=1, no click.
  - Else if REPEAT_CYCLES!=0 and cnt==REPEAT_CYCLES-1 -> repeat_pulse<=1, cnt<=0.
  - Else cnt<=cnt+1. With REPEAT_CYCLES=0, cnt saturates at all-ones (no wrap).
- held is registered: 1 in the cycle after entering SHORT, 0 in the cycle after returning to IDLE. It matches press_pulse/release_pulse timing.
- Latency:
  - Press edge sampled at edge N -> press_pulse high during cycle N+1.
  - Held continuously -> long_pulse issued at edge N+LONG_CYCLES.
  - First repeat at edge N+LONG_CYCLES+REPEAT_CYCLES, then every REPEAT_CYCLES.
- A 1-cycle glitch low then high (not expected after the debouncer) is treated as release then new press.
- Mutual exclusion: press, release, long and repeat never assert in the same cycle. click_pulse always coincides with a release_pulse.

Test Plan:
- Reset with btn_level=1 held, then release rst_n -> no press_pulse. Drop btn, raise at edge 10 -> press_pulse=1 at cycle 11 only, held=1 from 11.
- LONG_CYCLES=8, REPEAT_CYCLES=4, btn high edges 0..4, low at edge 5:
  - press_pulse after edge 0.
  - release_pulse and click_pulse after edge 5.
  - no long_pulse; held back to 0.
- Same params, btn high edges 0..19, low at edge 20:
  - press after edge 0, long_pulse after edge 8.
  - repeat_pulse after edges 12 and 16.
  - release after edge 20, no click_pulse.
- Boundary, btn high edges 0..7, low at edge 8 (release coincides with threshold) -> release+click after edge 8, no long_pulse.
- enable dropped at edge 5 while held -> held=0, no release_pulse. enable re-raised with btn still 1 -> no press; new 0->1 edge -> press_pulse.
- REPEAT_CYCLES=0, hold 100 cycles -> exactly one long_pulse, zero repeat_pulse. Async rst_n pulse mid-hold -> all outputs 0 immediately, no press afterwards while btn stays 1.
